// File: rtl/bus_uart_tx_if.sv
// CPU bus port of the memory-mapped UART transmitter: address/write path in,
// registered read data and window-hit strobe out.
interface bus_uart_tx_if;
  logic [15:0] Address;
  logic [7:0]  DataIn;
  logic        WE;
  logic [7:0]  DataOut;
  logic        SEL;

  modport master (output Address, DataIn, WE, input DataOut, SEL);
  modport slave  (input Address, DataIn, WE, output DataOut, SEL);
endinterface

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 serial transmitter with a small byte FIFO and a 4-register window.
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN.
module bus_uart_tx #(
  parameter logic [15:0] BASE      = 16'hFF00,
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  DIV_RESET = 8'd15
) (
  input  logic          CLK,
  input  logic          R,
  bus_uart_tx_if.slave  bus,
  output logic          TXD
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  // Bus decode
  logic       hit_c, wr_c;
  logic [1:0] off_c;
  assign hit_c = (bus.Address[15:2] == BASE[15:2]);
  assign off_c = bus.Address[1:0];
  assign wr_c  = bus.WE & hit_c;

  // Control registers
  logic [7:0] div_q;
  logic       en_q, ovf_q;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          full_c, empty_c, push_req_c, push_ok_c, pop_c;
  logic [7:0]    head_c;

  assign full_c     = (cnt_q == CW'(DEPTH));
  assign empty_c    = (cnt_q == '0);
  assign head_c     = mem_q[rptr_q];
  assign push_req_c = wr_c && (off_c == 2'd0);
  assign push_ok_c  = push_req_c && (!full_c || pop_c);

  // Shifter state
  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tmr_q, tmr_d;
  logic       par_q, par_d;
  logic       txd_q, txd_d;
  logic       bit_end_c;

  assign bit_end_c = (tmr_q == '0);
  assign TXD       = txd_q;

  always_ff @(posedge CLK) begin
    if (push_ok_c) mem_q[wptr_q] <= bus.DataIn;
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok_c) wptr_q <= wptr_q + PW'(1);
      if (pop_c)     rptr_q <= rptr_q + PW'(1);
      unique case ({push_ok_c, pop_c})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Register writes; a dropped push setting overflow beats a clearing write
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      div_q <= DIV_RESET;
      en_q  <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      if (wr_c && off_c == 2'd2) div_q <= bus.DataIn;
      if (wr_c && off_c == 2'd3) en_q  <= bus.DataIn[0];
      if (push_req_c && !push_ok_c)                     ovf_q <= 1'b1;
      else if (wr_c && off_c == 2'd1 && bus.DataIn[3])  ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tmr_q   <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tmr_q   <= tmr_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

  // Next state; the timer reloads DIV at every bit start so DIV changes land on a boundary
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tmr_d   = tmr_q;
    par_d   = par_q;
    pop_c   = 1'b0;
    txd_d   = 1'b1;

    if (state_q != S_IDLE && !bit_end_c) tmr_d = tmr_q - 8'd1;

    unique case (state_q)
      S_IDLE: begin
        if (en_q && !empty_c) pop_c = 1'b1;
      end
      S_START: begin
        if (bit_end_c) begin
          state_d = S_DATA;
          tmr_d   = div_q;
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          tmr_d   = div_q;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end_c) begin
          state_d = S_STOP;
          tmr_d   = div_q;
        end
      end
`endif
      S_STOP: begin
        if (bit_end_c) begin
          if (en_q && !empty_c) pop_c = 1'b1;
          else                  state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop_c) begin
      state_d = S_START;
      shift_d = head_c;
      bit_d   = '0;
      tmr_d   = div_q;
      par_d   = ^head_c;
    end

    unique case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = par_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  // Read mux, registered to match the memory's one-cycle read
  logic [7:0] rd_c;
  always_comb begin
    rd_c = '0;
    unique case (off_c)
      2'd0: rd_c = empty_c ? 8'h00 : head_c;
      2'd1: rd_c = {4'(cnt_q), ovf_q, (state_q != S_IDLE), empty_c, full_c};
      2'd2: rd_c = div_q;
      2'd3: rd_c = {6'b0, PAR_EN, en_q};
      default: rd_c = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      bus.DataOut <= '0;
      bus.SEL     <= 1'b0;
    end else begin
      bus.DataOut <= hit_c ? rd_c : 8'h00;
      bus.SEL     <= hit_c;
    end
  end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Self-checking bench for bus_uart_tx: directed scenarios plus random bus traffic
// checked every cycle against a frame-level timing model of the FIFO and serial line.
module tb_bus_uart_tx;

  localparam logic [15:0] BASE      = 16'hFF00;
  localparam int          DEPTH     = 4;
  localparam logic [7:0]  DIV_RESET = 8'd15;
  localparam logic [15:0] A_TX  = BASE;
  localparam logic [15:0] A_ST  = BASE + 16'd1;
  localparam logic [15:0] A_DIV = BASE + 16'd2;
  localparam logic [15:0] A_CTL = BASE + 16'd3;
`ifdef UART_TX_PARITY_EN
  localparam int NB  = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = 10;
  localparam bit PAR = 1'b0;
`endif

  logic CLK = 1'b0;
  logic R   = 1'b1;
  logic TXD;

  bus_uart_tx_if bus ();

  bus_uart_tx dut (.CLK(CLK), .R(R), .bus(bus), .TXD(TXD));

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, the shifter as "busy until cycle m_end"
  logic [7:0] m_q[$];
  bit         m_ovf, m_en, m_busy;
  logic [7:0] m_div, m_cur;
  int         m_cyc, m_start, m_end, m_bl;
  bit         chk_on;

  function automatic bit m_hit(input logic [15:0] a);
    return (a & 16'hFFFC) == BASE;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovf = 1'b0; m_en = 1'b1; m_busy = 1'b0;
    m_div = DIV_RESET; m_cur = 8'h00;
    m_cyc = 0; m_start = 0; m_end = 0; m_bl = 1;
  endtask

  function automatic logic [7:0] m_read(input logic [15:0] a);
    logic [3:0] cnt;
    if (!m_hit(a)) return 8'h00;
    cnt = 4'(m_q.size());
    case (a[1:0])
      2'd0:    return (m_q.size() > 0) ? m_q[0] : 8'h00;
      2'd1:    return {cnt, m_ovf, m_busy, (m_q.size() == 0), (m_q.size() == DEPTH)};
      2'd2:    return m_div;
      default: return {6'b0, PAR, m_en};
    endcase
  endfunction

  function automatic logic m_txd();
    int k;
    if (!m_busy) return 1'b1;
    k = (m_cyc - m_start) / m_bl;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    if (PAR && k == 9) return ^m_cur;
    return 1'b1;
  endfunction

  task automatic model_edge(input logic [15:0] a, input logic [7:0] d, input logic w);
    int sz;
    bit pop;
    m_cyc++;
    sz  = m_q.size();
    pop = m_en && sz > 0 && (!m_busy || m_cyc == m_end);
    if (m_busy && m_cyc == m_end) m_busy = 1'b0;
    if (pop) begin
      m_cur   = m_q.pop_front();
      m_busy  = 1'b1;
      m_start = m_cyc;
      m_bl    = int'(m_div) + 1;
      m_end   = m_cyc + NB * m_bl;
    end
    if (w && m_hit(a)) begin
      case (a[1:0])
        2'd0: if (sz < DEPTH || pop) m_q.push_back(d); else m_ovf = 1'b1;
        2'd1: if (d[3]) m_ovf = 1'b0;
        2'd2: m_div = d;
        default: m_en = d[0];
      endcase
    end
  endtask

  // One bus cycle: drive, clock, then compare read path and serial line
  task automatic step(input logic [15:0] a, input logic [7:0] d, input logic w);
    logic [7:0] er;
    logic       es, et;
    bus.Address = a;
    bus.DataIn  = d;
    bus.WE      = w;
    er = m_read(a);
    es = m_hit(a);
    @(posedge CLK);
    model_edge(a, d, w);
    et = m_txd();
    #1;
    if (chk_on) begin
      check("sel", bus.SEL, es);
      check("rdata", bus.DataOut, er);
      check("txd", TXD, et);
    end
    bus.WE = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_busy || m_q.size() != 0) && n < budget) begin
      step(A_ST, 8'h00, 1'b0);
      n++;
    end
    check("drain_timeout", (n < budget), 1);
  endtask

  initial begin
    int lo, hi, n, r;
    logic [15:0] a;
    bus.Address = '0; bus.DataIn = '0; bus.WE = 1'b0;
    chk_on = 1'b1;
    model_reset();
    #3 R = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_txd", TXD, 1);
    check("rst_sel", bus.SEL, 0);
    check("rst_dout", bus.DataOut, 0);
    @(negedge CLK) R = 1'b1;

    // Reset register values
    step(A_ST, 8'h00, 1'b0);
    step(A_DIV, 8'h00, 1'b0);
    step(A_CTL, 8'h00, 1'b0);

    // Single frame at DIV=3
    step(A_DIV, 8'd3, 1'b1);
    step(A_TX, 8'hA5, 1'b1);
    repeat (44) step(A_ST, 8'h00, 1'b0);

    // Overflow with transmitter disabled, then clear it
    step(A_DIV, 8'd0, 1'b1);
    step(A_CTL, 8'd0, 1'b1);
    for (int i = 1; i <= 5; i++) step(A_TX, 8'(i), 1'b1);
    step(A_ST, 8'h00, 1'b0);
    step(A_TX, 8'h00, 1'b0);
    step(A_ST, 8'h08, 1'b1);
    step(A_ST, 8'h00, 1'b0);

    // Enable and push on the popping edge while full
    step(A_CTL, 8'd1, 1'b1);
    step(A_TX, 8'h06, 1'b1);
    step(A_ST, 8'h00, 1'b0);
    wait_idle(200);

    // Parity / plain frame with 8'h07 and CTRL readback
    step(A_TX, 8'h07, 1'b1);
    repeat (14) step(A_ST, 8'h00, 1'b0);
    step(A_CTL, 8'h00, 1'b0);

    // DIV change mid-bit, then asynchronous reset mid-frame
    wait_idle(300);
    chk_on = 1'b0;
    step(A_DIV, 8'd3, 1'b1);
    step(A_TX, 8'h01, 1'b1);
    step(A_ST, 8'h00, 1'b0);
    check("div_start_low", TXD, 0);
    lo = 1;
    step(A_DIV, 8'd7, 1'b1);
    if (TXD == 1'b0) lo++;
    n = 0;
    while (TXD == 1'b0 && n < 40) begin
      step(A_ST, 8'h00, 1'b0);
      n++;
      if (TXD == 1'b0) lo++;
    end
    hi = 1;
    n = 0;
    while (TXD == 1'b1 && n < 40) begin
      step(A_ST, 8'h00, 1'b0);
      n++;
      if (TXD == 1'b1) hi++;
    end
    check("div_old_bit_len", lo, 4);
    check("div_new_bit_len", hi, 8);
    step(A_ST, 8'h00, 1'b0);
    step(A_ST, 8'h00, 1'b0);
    #2 R = 1'b0;
    #1;
    check("arst_txd", TXD, 1);
    check("arst_sel", bus.SEL, 0);
    check("arst_dout", bus.DataOut, 0);
    model_reset();
    @(negedge CLK) R = 1'b1;
    chk_on = 1'b1;
    step(A_ST, 8'h00, 1'b0);
    step(A_DIV, 8'h00, 1'b0);
    step(A_DIV, 8'd1, 1'b1);

    // Random bus traffic
    for (int i = 0; i < 2500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 35) begin
        step(BASE + 16'($urandom_range(0, 3)), 8'($urandom), 1'b0);
      end else if (r < 65) begin
        step(A_TX, 8'($urandom), 1'b1);
      end else if (r < 75) begin
        step(A_ST, 8'($urandom), 1'b1);
      end else if (r < 82) begin
        step(A_CTL, {7'($urandom), ($urandom_range(0, 9) != 0)}, 1'b1);
      end else if (r < 88) begin
        if (!m_busy && (m_q.size() == 0 || !m_en))
          step(A_DIV, 8'($urandom_range(0, 3)), 1'b1);
        else
          step(A_ST, 8'h00, 1'b0);
      end else begin
        a = 16'($urandom);
        if (m_hit(a)) a[8] = ~a[8];
        step(a, 8'($urandom), 1'($urandom));
      end
    end
    step(A_CTL, 8'd1, 1'b1);
    wait_idle(500);
    step(A_ST, 8'h00, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
